// File: rtl/affine_iter_gen_if.sv
// Control/output bundle between a schedule controller (master) and affine_iter_gen (slave).
interface affine_iter_gen_if #(
  parameter int ADDR_W = 16
);
  logic              clk_en;
  logic              flush;
  logic              step;
  logic [ADDR_W-1:0] addr_out;
  logic              last;
  logic              wrapped;

  modport master (
    output clk_en, flush, step,
    input  addr_out, last, wrapped
  );

  modport slave (
    input  clk_en, flush, step,
    output addr_out, last, wrapped
  );
endinterface

// File: rtl/affine_iter_gen.sv
// Step-driven affine address iterator: addr = starting_addr + sum(cnt[i] * stride[i]),
// kept incrementally through per-loop accumulators so no multipliers are needed.
module affine_iter_gen #(
  parameter int NUM_DIMS = 6,
  parameter int CNT_W    = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [3:0]                 dimensionality_i,
  input  logic [NUM_DIMS*CNT_W-1:0]  ranges_i,
  input  logic [NUM_DIMS*ADDR_W-1:0] strides_i,
  input  logic [ADDR_W-1:0]          starting_addr_i,
  affine_iter_gen_if.slave           ctl_if
);

  localparam logic [3:0]        MAX_DIM = 4'(NUM_DIMS);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [CNT_W-1:0]  cnt_q [NUM_DIMS];
  logic [CNT_W-1:0]  cnt_d [NUM_DIMS];
  logic [ADDR_W-1:0] acc_q [NUM_DIMS];
  logic [ADDR_W-1:0] acc_d [NUM_DIMS];
  logic [ADDR_W-1:0] offset_q;
  logic [ADDR_W-1:0] offset_d;
  logic              wrapped_q;

  logic [3:0]          dim_eff_s;
  logic [CNT_W-1:0]    rmax_s [NUM_DIMS];
  logic [NUM_DIMS-1:0] at_max_s;
  logic                last_s;
  logic                found_s;
  logic [ADDR_W-1:0]   inc_s;
  logic [ADDR_W-1:0]   sub_s;

  // Clamp the requested loop depth into 1..NUM_DIMS.
  always_comb begin
    if (dimensionality_i == 4'd0) begin
      dim_eff_s = 4'd1;
    end else if (dimensionality_i > MAX_DIM) begin
      dim_eff_s = MAX_DIM;
    end else begin
      dim_eff_s = dimensionality_i;
    end
  end

  // Per-loop terminal detection; inactive loops always count as saturated.
  always_comb begin
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (ranges_i[i*CNT_W +: CNT_W] == CNT_ZERO) begin
        rmax_s[i] = CNT_ZERO;
      end else begin
        rmax_s[i] = ranges_i[i*CNT_W +: CNT_W] - CNT_ONE;
      end
      // >= rather than == so an illegal mid-run config change cannot stall the walk
      at_max_s[i] = (4'(i) >= dim_eff_s) || (cnt_q[i] >= rmax_s[i]);
    end
  end

  assign last_s = &at_max_s;

  // Next iteration: bump the lowest unsaturated loop, clear the ones below it,
  // and move the offset by its stride minus the accumulated terms being dropped.
  always_comb begin
    found_s = 1'b0;
    inc_s   = ADDR_ZERO;
    sub_s   = ADDR_ZERO;
    for (int i = 0; i < NUM_DIMS; i++) begin
      cnt_d[i] = cnt_q[i];
      acc_d[i] = acc_q[i];
    end
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (found_s) begin
        cnt_d[i] = cnt_q[i];
        acc_d[i] = acc_q[i];
      end else if (!at_max_s[i]) begin
        found_s  = 1'b1;
        cnt_d[i] = cnt_q[i] + CNT_ONE;
        acc_d[i] = acc_q[i] + strides_i[i*ADDR_W +: ADDR_W];
        inc_s    = strides_i[i*ADDR_W +: ADDR_W];
      end else begin
        cnt_d[i] = CNT_ZERO;
        acc_d[i] = ADDR_ZERO;
        sub_s    = sub_s + acc_q[i];
      end
    end
    if (last_s) begin
      offset_d = ADDR_ZERO;
    end else begin
      offset_d = offset_q + inc_s - sub_s;
    end
  end

  // Iteration state: reset > enable gate > flush > step > idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIMS; i++) begin
        cnt_q[i] <= CNT_ZERO;
        acc_q[i] <= ADDR_ZERO;
      end
      offset_q  <= ADDR_ZERO;
      wrapped_q <= 1'b0;
    end else if (ctl_if.clk_en) begin
      if (ctl_if.flush) begin
        for (int i = 0; i < NUM_DIMS; i++) begin
          cnt_q[i] <= CNT_ZERO;
          acc_q[i] <= ADDR_ZERO;
        end
        offset_q  <= ADDR_ZERO;
        wrapped_q <= 1'b0;
      end else if (ctl_if.step) begin
        for (int i = 0; i < NUM_DIMS; i++) begin
          cnt_q[i] <= cnt_d[i];
          acc_q[i] <= acc_d[i];
        end
        offset_q  <= offset_d;
        wrapped_q <= last_s;
      end else begin
        wrapped_q <= 1'b0;
      end
    end
  end

  assign ctl_if.addr_out = starting_addr_i + offset_q;
  assign ctl_if.last     = last_s;
  assign ctl_if.wrapped  = wrapped_q;

endmodule

// File: tb/tb_affine_iter_gen.sv
// Scoreboard bench for affine_iter_gen: the driver pushes model expectations per cycle,
// a negedge monitor pops and compares; a few directed constant spot checks on top.
module tb_affine_iter_gen;

  logic        clk;
  logic        rst;
  logic [3:0]  dim;
  int          rng [6];
  int          str [6];
  logic [15:0] start;
  logic [95:0] ranges_s;
  logic [95:0] strides_s;

  affine_iter_gen_if #(.ADDR_W(16)) bus ();

  affine_iter_gen #(.NUM_DIMS(6), .CNT_W(16), .ADDR_W(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dimensionality_i(dim),
    .ranges_i        (ranges_s),
    .strides_i       (strides_s),
    .starting_addr_i (start),
    .ctl_if          (bus)
  );

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      ranges_s[i*16 +: 16]  = 16'(rng[i]);
      strides_s[i*16 +: 16] = 16'(str[i]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        last;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_cnt [6];
  bit   m_wr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_dim();
    int d;
    d = int'(dim);
    if (d == 0) d = 1;
    if (d > 6) d = 6;
    return d;
  endfunction

  function automatic int m_rng(int i);
    return (rng[i] == 0) ? 1 : rng[i];
  endfunction

  function automatic bit m_last();
    for (int i = 0; i < m_dim(); i++)
      if (m_cnt[i] != m_rng(i) - 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_addr();
    int s;
    s = int'(start);
    for (int i = 0; i < m_dim(); i++) s = s + m_cnt[i] * str[i];
    return 16'(s);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    m_wr = 1'b0;
  endtask

  task automatic m_advance();
    bit done;
    if (m_last()) begin
      m_clear();
      m_wr = 1'b1;
    end else begin
      done = 1'b0;
      for (int i = 0; i < m_dim(); i++) begin
        if (!done) begin
          if (m_cnt[i] < m_rng(i) - 1) begin
            m_cnt[i]++;
            done = 1'b1;
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
      m_wr = 1'b0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.addr = m_addr();
    e.last = m_last();
    e.wr   = m_wr;
    sb_q.push_back(e);
  endtask

  // One clock: drive controls, advance the model, queue the post-edge expectation.
  task automatic cyc(bit st, bit fl, bit en);
    bus.step   = st;
    bus.flush  = fl;
    bus.clk_en = en;
    if (en) begin
      if (fl) m_clear();
      else if (st) m_advance();
      else m_wr = 1'b0;
    end
    @(posedge clk);
    #1;
    push_exp();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_addr", 32'(bus.addr_out), 32'(mon_e.addr));
      chk("sb_last", 32'(bus.last), 32'(mon_e.last));
      chk("sb_wrapped", 32'(bus.wrapped), 32'(mon_e.wr));
    end
  end

  initial begin
    rst = 1'b1;
    bus.step = 1'b0;
    bus.flush = 1'b0;
    bus.clk_en = 1'b1;
    dim = 4'd2;
    for (int i = 0; i < 6; i++) begin
      rng[i] = 0;
      str[i] = 0;
    end
    rng[0] = 5; str[0] = 2;
    rng[1] = 6; str[1] = 11;
    start = 16'd10;
    m_clear();
    #2;
    push_exp();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Base sequence: two full passes with step held high
    for (int i = 0; i < 60; i++) begin
      if (i == 29) begin
        chk("base_last_addr", 32'(bus.addr_out), 32'd73);
        chk("base_last_flag", 32'(bus.last), 32'd1);
      end
      if (i == 30) begin
        chk("base_wrap_addr", 32'(bus.addr_out), 32'd10);
        chk("base_wrap_pulse", 32'(bus.wrapped), 32'd1);
      end
      cyc(1'b1, 1'b0, 1'b1);
    end

    // Enable/idle: frozen while clk_en=0, including a held wrapped pulse
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);

    // Flush with simultaneous step at addr 23
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("flush_pre_addr", 32'(bus.addr_out), 32'd23);
    cyc(1'b1, 1'b1, 1'b1);
    chk("flush_addr", 32'(bus.addr_out), 32'd10);
    chk("flush_wrapped", 32'(bus.wrapped), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("flush_next", 32'(bus.addr_out), 32'd12);

    // Async reset between edges at addr 21
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("rst_pre_addr", 32'(bus.addr_out), 32'd21);
    settle();
    rst = 1'b1;
    m_clear();
    #1;
    chk("rst_addr", 32'(bus.addr_out), 32'd10);
    chk("rst_wrapped", 32'(bus.wrapped), 32'd0);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    chk("rst_next", 32'(bus.addr_out), 32'd12);
    cyc(1'b1, 1'b0, 1'b1);

    // Degenerate: dim=0, range0=0 -> last constant, wrapped held while stepping
    settle();
    dim = 4'd0;
    rng[0] = 0;
    start = 16'h0040;
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("degen_addr", 32'(bus.addr_out), 32'h40);
    chk("degen_wrapped", 32'(bus.wrapped), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);

    // Address wrap-around modulo 2^16
    settle();
    dim = 4'd1;
    rng[0] = 2; str[0] = 32'h20;
    start = 16'hFFF0;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("modwrap_addr", 32'(bus.addr_out), 32'h0010);
    cyc(1'b1, 1'b0, 1'b1);

    // 6-D binary counter, then dimensionality above NUM_DIMS clamps to 6
    settle();
    dim = 4'd6;
    for (int i = 0; i < 6; i++) begin
      rng[i] = 2;
      str[i] = 1 << i;
    end
    start = 16'h0100;
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        chk("d6_last_addr", 32'(bus.addr_out), 32'h013F);
        chk("d6_last_flag", 32'(bus.last), 32'd1);
      end
      cyc(1'b1, 1'b0, 1'b1);
    end
    chk("d6_wrap_addr", 32'(bus.addr_out), 32'h0100);
    settle();
    dim = 4'd15;
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("dclamp_addr", 32'(bus.addr_out), 32'h0128);

    settle();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
